// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types and constants for the MEM-stage access unit
package mem_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam int          CNT_W      = 8;
   localparam logic [1:0]  ALIGN_MASK = 2'b00;

   function automatic logic is_aligned(input logic [31:0] addr);
      return addr[1:0] == ALIGN_MASK;
   endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// rtl/mem_access_stage_if.sv - req/ack data-memory bus between MEM stage and memory
interface mem_access_stage_if;
   logic        dreq;
   logic        dwe;
   logic [31:0] daddr;
   logic [31:0] dwdata;
   logic [31:0] drdata;
   logic        dack;

   modport master (output dreq, dwe, daddr, dwdata, input drdata, dack);
   modport slave  (input dreq, dwe, daddr, dwdata, output drdata, dack);
endinterface

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - MEM-stage load/store unit: runs one bus transaction per
// access, stalls the pipeline while it is outstanding, flags misalignment/timeouts.
module mem_access_stage
   import mem_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                 clk,
   input  logic                 clrn,
   input  logic                 mwmem,
   input  logic                 mm2reg,
   input  logic [31:0]          maluout,
   input  logic [31:0]          mb,
   mem_access_stage_if.master   bus,
   output logic [31:0]          dataout,
   output logic                 mem_stall,
   output logic                 mem_err
);

   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   state_t            r_state;
   state_t            w_next_state;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_is_load;
   logic              r_dreq;
   logic              r_dwe;
   logic [31:0]       r_daddr;
   logic [31:0]       r_dwdata;
   logic [31:0]       r_dataout;
   logic              r_err;

   logic              w_access;
   logic              w_aligned;
   logic              w_timeout;

   assign w_access  = mwmem | mm2reg;
   assign w_aligned = is_aligned(maluout);
   // dack on the final cycle takes priority over the timeout
   assign w_timeout = (r_cnt == TO_LAST) & ~bus.dack;

   assign bus.dreq   = r_dreq;
   assign bus.dwe    = r_dwe;
   assign bus.daddr  = r_daddr;
   assign bus.dwdata = r_dwdata;
   assign dataout    = r_dataout;
   assign mem_err    = r_err;

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      mem_stall    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            mem_stall = w_access & w_aligned;
            if (w_access && w_aligned) begin
               w_next_state = ST_BUSY;
            end
         end
         ST_BUSY: begin
            mem_stall = 1'b1;
            if (bus.dack || w_timeout) begin
               w_next_state = ST_DONE;
            end
         end
         ST_DONE: begin
            w_next_state = ST_IDLE;
         end
         default: begin
            w_next_state = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         r_cnt     <= '0;
         r_is_load <= 1'b0;
         r_dreq    <= 1'b0;
         r_dwe     <= 1'b0;
         r_daddr   <= '0;
         r_dwdata  <= '0;
         r_dataout <= '0;
         r_err     <= 1'b0;
      end else begin
         r_err <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_access && w_aligned) begin
                  r_daddr   <= maluout;
                  r_dwdata  <= mb;
                  r_dwe     <= mwmem;
                  r_is_load <= ~mwmem;
                  r_dreq    <= 1'b1;
                  r_cnt     <= '0;
               end else if (w_access) begin
                  r_err     <= 1'b1;
                  r_dataout <= '0;
               end
            end
            ST_BUSY: begin
               r_cnt <= r_cnt + 1'b1;
               if (bus.dack) begin
                  r_dreq <= 1'b0;
                  r_dwe  <= 1'b0;
                  if (r_is_load) begin
                     r_dataout <= bus.drdata;
                  end
               end else if (w_timeout) begin
                  r_dreq    <= 1'b0;
                  r_dwe     <= 1'b0;
                  r_err     <= 1'b1;
                  r_dataout <= '0;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - self-checking bench for mem_access_stage
module tb_mem_access_stage;

   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        clrn = 1'b0;
   logic        mwmem = 1'b0;
   logic        mm2reg = 1'b0;
   logic [31:0] maluout = '0;
   logic [31:0] mb = '0;
   logic [31:0] dataout;
   logic        mem_stall;
   logic        mem_err;

   mem_access_stage_if bus_if ();

   mem_access_stage #(.TIMEOUT_CYCLES(TO)) dut (
      .clk       (clk),
      .clrn      (clrn),
      .mwmem     (mwmem),
      .mm2reg    (mm2reg),
      .maluout   (maluout),
      .mb        (mb),
      .bus       (bus_if),
      .dataout   (dataout),
      .mem_stall (mem_stall),
      .mem_err   (mem_err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   // transaction-level reference: phase 0 waiting for work, 1 bus outstanding, 2 completing
   int          m_phase;
   int          m_wait;
   bit          m_is_load;
   bit          m_dreq;
   bit          m_dwe;
   bit          m_err;
   logic [31:0] m_daddr;
   logic [31:0] m_dwdata;
   logic [31:0] m_dataout;

   bit          s_stall, s_dreq, s_dwe, s_err;
   logic [31:0] s_dataout, s_daddr, s_dwdata;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_phase   = 0;
      m_wait    = 0;
      m_is_load = 1'b0;
      m_dreq    = 1'b0;
      m_dwe     = 1'b0;
      m_err     = 1'b0;
      m_daddr   = '0;
      m_dwdata  = '0;
      m_dataout = '0;
   endtask

   task automatic step(input bit mw, input bit mr, input logic [31:0] a, input logic [31:0] d,
                       input bit ack, input logic [31:0] rd);
      bit acc;
      bit exp_stall;
      @(negedge clk);
      mwmem = mw; mm2reg = mr; maluout = a; mb = d;
      bus_if.dack = ack; bus_if.drdata = rd;
      #1;
      s_stall = mem_stall; s_dreq = bus_if.dreq; s_dwe = bus_if.dwe; s_err = mem_err;
      s_dataout = dataout; s_daddr = bus_if.daddr; s_dwdata = bus_if.dwdata;
      acc = mw | mr;
      exp_stall = (m_phase == 1) || (m_phase == 0 && acc && a[1:0] == 2'b00);
      check("stall", 32'(s_stall), 32'(exp_stall));
      check("dreq", 32'(s_dreq), 32'(m_dreq));
      check("err", 32'(s_err), 32'(m_err));
      check("dataout", s_dataout, m_dataout);
      check("daddr", s_daddr, m_daddr);
      check("dwdata", s_dwdata, m_dwdata);
      if (m_dreq) check("dwe", 32'(s_dwe), 32'(m_dwe));
      m_err = 1'b0;
      case (m_phase)
         0: if (acc) begin
               if (a[1:0] == 2'b00) begin
                  m_phase = 1; m_wait = 0; m_dreq = 1'b1; m_dwe = mw;
                  m_daddr = a; m_dwdata = d; m_is_load = !mw;
               end else begin
                  m_err = 1'b1; m_dataout = '0;
               end
            end
         1: if (ack) begin
               m_dreq = 1'b0; m_dwe = 1'b0; m_phase = 2;
               if (m_is_load) m_dataout = rd;
            end else if (m_wait == TO - 1) begin
               m_dreq = 1'b0; m_dwe = 1'b0; m_err = 1'b1; m_dataout = '0; m_phase = 2;
            end else begin
               m_wait++;
            end
         default: m_phase = 0;
      endcase
   endtask

   task automatic do_reset();
      @(negedge clk);
      mwmem = 1'b0; mm2reg = 1'b0; bus_if.dack = 1'b0;
      clrn = 1'b0;
      #1;
      model_reset();
      check("rst_dreq", 32'(bus_if.dreq), 32'd0);
      check("rst_stall", 32'(mem_stall), 32'd0);
      check("rst_dataout", dataout, 32'd0);
      check("rst_err", 32'(mem_err), 32'd0);
      check("rst_daddr", bus_if.daddr, 32'd0);
      #2 clrn = 1'b1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int n_stall;
      int n_dreq;
      int n_err;
      bit mw, mr;
      logic [31:0] a;
      bus_if.dack = 1'b0;
      bus_if.drdata = '0;
      model_reset();
      #1;
      check("init_dreq", 32'(bus_if.dreq), 32'd0);
      check("init_dataout", dataout, 32'd0);
      check("init_err", 32'(mem_err), 32'd0);
      @(negedge clk);
      #2 clrn = 1'b1;

      // load with ack in first BUSY cycle
      step(0, 1, 32'h10, 32'h0, 0, 32'h0);
      check("ld_stall_idle", 32'(s_stall), 32'd1);
      step(0, 1, 32'h10, 32'h0, 1, 32'hDEADBEEF);
      check("ld_stall_busy", 32'(s_stall), 32'd1);
      check("ld_daddr", s_daddr, 32'h10);
      check("ld_dwe", 32'(s_dwe), 32'd0);
      step(0, 0, 32'h0, 32'h0, 0, 32'h0);
      check("ld_stall_done", 32'(s_stall), 32'd0);
      check("ld_dataout", s_dataout, 32'hDEADBEEF);
      check("ld_err", 32'(s_err), 32'd0);

      // store, ack after 3 BUSY cycles
      n_stall = 0; n_dreq = 0;
      for (int i = 0; i < 5; i++) begin
         step(i < 4, 0, 32'h20, 32'h12345678, i == 3, 32'hFFFF0000);
         n_stall += int'(s_stall);
         n_dreq += int'(s_dreq);
         if (i == 2) begin
            check("st_dwe", 32'(s_dwe), 32'd1);
            check("st_dwdata", s_dwdata, 32'h12345678);
         end
      end
      check("st_stall_cycles", n_stall, 32'd4);
      check("st_dreq_cycles", n_dreq, 32'd3);
      check("st_dataout_kept", s_dataout, 32'hDEADBEEF);

      // misaligned load
      step(0, 1, 32'h13, 32'h0, 0, 32'h0);
      check("mis_stall", 32'(s_stall), 32'd0);
      step(0, 0, 32'h0, 32'h0, 0, 32'h0);
      check("mis_err", 32'(s_err), 32'd1);
      check("mis_dataout", s_dataout, 32'd0);
      check("mis_dreq", 32'(s_dreq), 32'd0);
      step(0, 0, 32'h0, 32'h0, 0, 32'h0);
      check("mis_err_pulse", 32'(s_err), 32'd0);

      // back-to-back loads with stray acks outside BUSY
      step(0, 0, 32'h0, 32'h0, 1, 32'hBAD0BAD0);
      step(0, 1, 32'h4, 32'h0, 0, 32'h0);
      step(0, 1, 32'h4, 32'h0, 1, 32'h1);
      step(0, 1, 32'h4, 32'h0, 1, 32'hBAD1BAD1);
      check("b2b_done1_stall", 32'(s_stall), 32'd0);
      check("b2b_data1", s_dataout, 32'h1);
      step(0, 1, 32'h8, 32'h0, 0, 32'h0);
      check("b2b_gap_dreq", 32'(s_dreq), 32'd0);
      check("b2b_idle2_stall", 32'(s_stall), 32'd1);
      step(0, 1, 32'h8, 32'h0, 1, 32'h2);
      check("b2b_daddr2", s_daddr, 32'h8);
      step(0, 0, 32'h0, 32'h0, 1, 32'hBAD2BAD2);
      check("b2b_data2", s_dataout, 32'h2);
      step(0, 0, 32'h0, 32'h0, 0, 32'h0);
      check("b2b_data2_hold", s_dataout, 32'h2);

      // timeout with no ack
      n_dreq = 0; n_err = 0;
      step(0, 1, 32'h40, 32'h0, 0, 32'h0);
      for (int i = 0; i < 8; i++) begin
         step(0, 0, 32'h0, 32'h0, 0, 32'h0);
         n_dreq += int'(s_dreq);
         n_err += int'(s_err);
      end
      check("to_dreq_cycles", n_dreq, 32'd4);
      check("to_err_cycles", n_err, 32'd1);
      check("to_dataout", s_dataout, 32'd0);

      // asynchronous reset in the middle of a transaction
      step(0, 1, 32'h100, 32'h0, 0, 32'h0);
      step(0, 1, 32'h100, 32'h0, 0, 32'h0);
      check("midrst_busy_dreq", 32'(s_dreq), 32'd1);
      do_reset();

      // randomized traffic against the reference
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 499) == 0) begin
            do_reset();
         end else begin
            mw = ($urandom_range(0, 3) == 0);
            mr = ($urandom_range(0, 2) == 0);
            a = $urandom;
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            step(mw, mr, a, $urandom, ($urandom_range(0, 9) < 3), $urandom);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- MEM-stage data-memory access unit between the EX/MEM and MEM/WB pipeline registers.
- Takes the EX/MEM control and data (mwmem, mm2reg, maluout as address, mb as store data) and runs a req/ack transaction on the data-memory bus.
- Freezes the pipeline via mem_stall while a transaction is outstanding, and presents the load result on dataout for the MEM/WB register to capture.
- Flags misaligned accesses and bus timeouts on mem_err.

Parameters:
- TIMEOUT_CYCLES, 255: cycles in BUSY without dack before the transaction is aborted (range 1..255; 8-bit counter).

Ports:
- clk  in  1  system clock, rising edge
- clrn  in  1  asynchronous active-low reset
- mwmem  in  1  store request from EX/MEM
- mm2reg  in  1  load request from EX/MEM
- maluout  in  32  byte address from EX/MEM
- mb  in  32  store data from EX/MEM
- dreq  out  1  bus request, held high until dack or timeout
- dwe  out  1  bus write enable, valid while dreq=1
- daddr  out  32  word-aligned bus address, latched
- dwdata  out  32  bus store data, latched
- drdata  in  32  bus read data, sampled when dack=1
- dack  in  1  bus acknowledge, single-cycle pulse
- dataout  out  32  load result to MEM/WB
- mem_stall  out  1  freeze PC, IF/ID, ID/EX, EX/MEM; MEM/WB must not latch
- mem_err  out  1  one-cycle pulse: misaligned access or timeout

Behaviour:
- Reset (clrn=0, asynchronous):
  - state=IDLE, counter=0.
  - dreq, dwe, daddr, dwdata, dataout, mem_err = 0.
  - Reset mid-transaction aborts it immediately. No ack is awaited.
- access = mwmem | mm2reg. If both are set, the access is treated as a store (mwmem wins).
- States: IDLE, BUSY, DONE. Encoding is local to the package.
- IDLE:
  - mem_stall = access & aligned, combinational, in the same cycle.
  - Aligned access (maluout[1:0]==0): at the next edge latch daddr=maluout, dwdata=mb, dwe=mwmem; set dreq=1, counter=0; go to BUSY.
  - Misaligned access: no bus request, no stall; at the next edge mem_err=1 for one cycle, dataout=0; stay in IDLE.
  - No access: hold. dack is ignored.
- BUSY:
  - mem_stall=1, counter increments each cycle.
  - dack=1: at that edge dreq=0, dwe=0; if the access was a load, dataout=drdata, otherwise dataout is unchanged; go to DONE.
  - counter==TIMEOUT_CYCLES-1 with no dack: at that edge dreq=0, mem_err=1 (one cycle), dataout=0; go to DONE.
  - dack in the same cycle as the timeout: dack wins, no error.
- DONE:
  - mem_stall=0. MEM/WB captures dataout at this edge and the pipeline advances.
  - Always returns to IDLE. Any access present in this cycle is the completing instruction and is not re-issued.
  - A new instruction is evaluated in the following IDLE cycle.
- Latency: a load with dack in its first BUSY cycle stalls for 2 cycles (IDLE-access, BUSY); the result is valid in DONE.
- dataout holds its value outside updates. mem_err is registered and never high for more than one cycle per event.
- dack outside BUSY is ignored.

Decomposition:
- Shared package mem_pkg: state enum (IDLE/BUSY/DONE), TIMEOUT counter width constant (8), ALIGN_MASK = 2'b00.
- No sub-module. FSM, counter and latches sit in one module (about 150-200 lines).

Test Plan:
- Reset then idle: clrn low mid-BUSY → dreq=0, state IDLE, dataout=0, mem_stall=0 immediately, with no clock edge required.
- Load, addr 0x00000010, dack after 1 cycle with drdata=0xDEADBEEF → mem_stall high 2 cycles, daddr=0x10, dwe=0, dataout=0xDEADBEEF in DONE, mem_err=0.
- Store, addr 0x00000020, mb=0x12345678, dack after 3 cycles → dreq high 3 cycles, dwe=1, dwdata=0x12345678, dataout unchanged, mem_stall 4 cycles.
- Misaligned load, addr 0x00000013 → dreq stays 0, mem_stall=0, mem_err pulses 1 cycle, dataout=0.
- Timeout: TIMEOUT_CYCLES=4, load with no dack → dreq high exactly 4 cycles, then mem_err=1 for 1 cycle, dataout=0, return to IDLE.
- Back-to-back loads, addrs 0x4 then 0x8, immediate dacks with data 0x1 and 0x2 → two separate transactions with an IDLE cycle between, dataout=0x1 then 0x2, and no spurious dack effects.
